// File: rtl/clk_div_pkg.sv
// Shared definitions for the glitch-free selectable clock divider:
// sizing, FSM state encoding and counter boundary helpers.
package clk_div_pkg;

    localparam int NUM_STAGES = 22;
    localparam int SEL_W      = 5;

    typedef enum logic [1:0] {
        ST_STOP   = 2'd0,
        ST_RUN    = 2'd1,
        ST_SWITCH = 2'd2
    } state_e;

    // True when cnt[m:0] is all ones, i.e. the next increment zeroes taps 0..m.
    function automatic logic at_boundary(input logic [NUM_STAGES-1:0] cnt,
                                         input logic [SEL_W-1:0]      m);
        logic [NUM_STAGES-1:0] mask;
        mask = {NUM_STAGES{1'b1}} >> (NUM_STAGES - 1 - int'(m));
        return ((cnt & mask) == mask);
    endfunction

    function automatic logic [SEL_W-1:0] sel_max(input logic [SEL_W-1:0] a,
                                                 input logic [SEL_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/clk_div_sel_ctrl_if.sv
// Tap-select request channel: valid/ready handshake plus discard-error pulse.
interface clk_div_sel_ctrl_if;
    import clk_div_pkg::*;

    logic             sel_valid;
    logic [SEL_W-1:0] sel_data;
    logic             sel_ready;
    logic             sel_err;

    modport master (output sel_valid, output sel_data, input sel_ready, input sel_err);
    modport slave  (input sel_valid, input sel_data, output sel_ready, output sel_err);

endinterface

// File: rtl/clk_div_sel_ctrl_div_counter.sv
// Free-running divider counter; every bit k is the f/2^(k+1) tap.
// cnt_next is exported so output flops can look one edge ahead.
module div_counter
    import clk_div_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  clr,
    output logic [NUM_STAGES-1:0] cnt,
    output logic [NUM_STAGES-1:0] cnt_next
);

    logic [NUM_STAGES-1:0] cnt_r;

    // Next-count selection: clear wins over increment.
    always_comb begin
        if (clr) begin
            cnt_next = {NUM_STAGES{1'b0}};
        end else if (en) begin
            cnt_next = cnt_r + {{(NUM_STAGES-1){1'b0}}, 1'b1};
        end else begin
            cnt_next = cnt_r;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {NUM_STAGES{1'b0}};
        end else begin
            cnt_r <= cnt_next;
        end
    end

    assign cnt = cnt_r;

endmodule

// File: rtl/clk_div_sel_ctrl.sv
// Selectable divided-clock generator: one counter, registered tap output,
// tap changes and stops only at counter boundaries where both taps are low.
module clk_div_sel_ctrl
    import clk_div_pkg::*;
(
    input  logic              clk_in,
    input  logic              rst,
    input  logic              run,
    clk_div_sel_ctrl_if.slave sel_if,
    output logic [SEL_W-1:0]  active_sel,
    output logic              clk_out,
    output logic              tick_out,
    output logic              busy
);

    state_e                state_r;
    state_e                state_next_s;
    logic [SEL_W-1:0]      active_sel_r;
    logic [SEL_W-1:0]      sel_next_s;
    logic [SEL_W-1:0]      pend_sel_r;
    logic [SEL_W-1:0]      pend_next_s;
    logic [NUM_STAGES-1:0] cnt_s;
    logic [NUM_STAGES-1:0] cnt_next_s;
    logic                  sel_ready_r;
    logic                  sel_err_r;
    logic                  clk_out_r;
    logic                  tick_out_r;
    logic                  busy_r;
    logic                  hs_s;
    logic                  sel_in_range_s;
    logic                  req_ok_s;
    logic                  err_next_s;
    logic                  cnt_en_s;
    logic                  cnt_clr_s;
    logic                  out_bit_s;

    assign hs_s           = sel_if.sel_valid & sel_ready_r;
    assign sel_in_range_s = (sel_if.sel_data < SEL_W'(NUM_STAGES));
    assign req_ok_s       = hs_s & sel_in_range_s;
    assign err_next_s     = hs_s & ~sel_in_range_s;

    // Next-state, next-tap and pending-tap decode.
    always_comb begin
        state_next_s = state_r;
        sel_next_s   = active_sel_r;
        pend_next_s  = pend_sel_r;
        case (state_r)
            ST_STOP: begin
                if (req_ok_s) begin
                    sel_next_s = sel_if.sel_data;
                end else begin
                    sel_next_s = active_sel_r;
                end
                if (run) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_STOP;
                end
            end
            ST_RUN: begin
                if (req_ok_s && (sel_if.sel_data != active_sel_r)) begin
                    pend_next_s  = sel_if.sel_data;
                    state_next_s = ST_SWITCH;
                end else if (!run && at_boundary(cnt_s, active_sel_r)) begin
                    state_next_s = ST_STOP;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_SWITCH: begin
                // Wait for the slower tap's boundary so both taps restart low together.
                if (at_boundary(cnt_s, sel_max(active_sel_r, pend_sel_r))) begin
                    sel_next_s   = pend_sel_r;
                    state_next_s = run ? ST_RUN : ST_STOP;
                end else begin
                    state_next_s = ST_SWITCH;
                end
            end
            default: begin
                state_next_s = ST_STOP;
                sel_next_s   = {SEL_W{1'b0}};
            end
        endcase
    end

    assign cnt_en_s  = (state_next_s != ST_STOP);
    assign cnt_clr_s = (state_r != ST_STOP) && (state_next_s == ST_STOP);
    assign out_bit_s = cnt_next_s[sel_next_s];

    div_counter u_div_counter (
        .clk      (clk_in),
        .rst      (rst),
        .en       (cnt_en_s),
        .clr      (cnt_clr_s),
        .cnt      (cnt_s),
        .cnt_next (cnt_next_s)
    );

    // FSM state and registered outputs, all updated from next-edge values.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_r      <= ST_STOP;
            active_sel_r <= {SEL_W{1'b0}};
            pend_sel_r   <= {SEL_W{1'b0}};
            clk_out_r    <= 1'b0;
            tick_out_r   <= 1'b0;
            sel_err_r    <= 1'b0;
            busy_r       <= 1'b0;
            sel_ready_r  <= 1'b1;
        end else begin
            state_r      <= state_next_s;
            active_sel_r <= sel_next_s;
            pend_sel_r   <= pend_next_s;
            clk_out_r    <= out_bit_s;
            tick_out_r   <= out_bit_s & ~clk_out_r & (state_next_s != ST_STOP);
            sel_err_r    <= err_next_s;
            busy_r       <= (state_next_s != ST_STOP);
            sel_ready_r  <= (state_next_s != ST_SWITCH);
        end
    end

    assign active_sel       = active_sel_r;
    assign clk_out          = clk_out_r;
    assign tick_out         = tick_out_r;
    assign busy             = busy_r;
    assign sel_if.sel_ready = sel_ready_r;
    assign sel_if.sel_err   = sel_err_r;

endmodule

// File: tb/tb_clk_div_sel_ctrl.sv
// Self-checking bench for clk_div_sel_ctrl: a cycle model feeds an expected-value
// queue, observed outputs are queued at the falling edge and drained per scenario.
module tb_clk_div_sel_ctrl;
    import clk_div_pkg::*;

    localparam int S_STOP = 0;
    localparam int S_RUN  = 1;
    localparam int S_SW   = 2;

    typedef logic [SEL_W+4:0] obs_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             run = 1'b0;
    logic [SEL_W-1:0] active_sel;
    logic             clk_out;
    logic             tick_out;
    logic             busy;

    int n_checks = 0;
    int n_fail   = 0;

    obs_t exp_q[$];
    obs_t obs_q[$];

    int          m_st   = S_STOP;
    int unsigned m_cnt  = 0;
    int          m_act  = 0;
    int          m_pend = 0;
    bit          m_clk  = 1'b0;
    bit          m_tick = 1'b0;
    bit          m_busy = 1'b0;
    bit          m_ready = 1'b1;
    bit          m_err  = 1'b0;

    clk_div_sel_ctrl_if sel_if ();

    clk_div_sel_ctrl dut (
        .clk_in     (clk),
        .rst        (rst),
        .run        (run),
        .sel_if     (sel_if),
        .active_sel (active_sel),
        .clk_out    (clk_out),
        .tick_out   (tick_out),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    function automatic bit m_bnd(input int m);
        return ((m_cnt + 32'd1) % (32'd1 << (m + 1))) == 32'd0;
    endfunction

    // Reference behaviour for one clock edge using the inputs present before it.
    task automatic model_step();
        int          ns;
        int          nsel;
        int          np;
        int unsigned ncnt;
        bit          hs;
        bit          ok;
        bit          bitv;
        if (rst) begin
            m_st = S_STOP; m_cnt = 0; m_act = 0; m_pend = 0;
            m_clk = 1'b0; m_tick = 1'b0; m_busy = 1'b0; m_ready = 1'b1; m_err = 1'b0;
            return;
        end
        hs   = sel_if.sel_valid && m_ready;
        ok   = hs && (int'(sel_if.sel_data) < NUM_STAGES);
        ns   = m_st;
        nsel = m_act;
        np   = m_pend;
        case (m_st)
            S_STOP: begin
                if (ok) nsel = int'(sel_if.sel_data);
                if (run) ns = S_RUN;
            end
            S_RUN: begin
                if (ok && int'(sel_if.sel_data) != m_act) begin
                    np = int'(sel_if.sel_data);
                    ns = S_SW;
                end else if (!run && m_bnd(m_act)) begin
                    ns = S_STOP;
                end
            end
            S_SW: begin
                if (m_bnd((m_act > m_pend) ? m_act : m_pend)) begin
                    nsel = m_pend;
                    ns   = run ? S_RUN : S_STOP;
                end
            end
            default: ns = S_STOP;
        endcase
        ncnt    = (ns == S_STOP) ? 32'd0 : ((m_cnt + 32'd1) & 32'h003F_FFFF);
        bitv    = ncnt[nsel];
        m_tick  = bitv && !m_clk && (ns != S_STOP);
        m_clk   = bitv;
        m_err   = hs && !ok;
        m_busy  = (ns != S_STOP);
        m_ready = (ns != S_SW);
        m_st    = ns;
        m_act   = nsel;
        m_pend  = np;
        m_cnt   = ncnt;
    endtask

    task automatic cycle();
        logic [SEL_W-1:0] a;
        model_step();
        a = m_act[SEL_W-1:0];
        exp_q.push_back({a, m_clk, m_tick, m_busy, m_ready, m_err});
        @(posedge clk);
        @(negedge clk);
        obs_q.push_back({active_sel, clk_out, tick_out, busy, sel_if.sel_ready, sel_if.sel_err});
    endtask

    task automatic test_reset();
        obs_t e;
        obs_t o;
        rst = 1'b1; run = 1'b0;
        sel_if.sel_valid = 1'b0; sel_if.sel_data = 5'd0;
        repeat (3) cycle();
        n_checks++;
        if ({active_sel, clk_out, tick_out, busy, sel_if.sel_ready, sel_if.sel_err} !== 10'b00000_0_0_0_1_0) begin
            n_fail++;
            $display("FAIL reset_values: got sel=%0d clk=%b tick=%b busy=%b rdy=%b err=%b, need 0 0 0 0 1 0",
                     active_sel, clk_out, tick_out, busy, sel_if.sel_ready, sel_if.sel_err);
        end
        rst = 1'b0;
        cycle();
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy: got %b need 0", busy); end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL reset_trace: got %h need %h", o, e); end
        end
    endtask

    task automatic test_tap0();
        obs_t e;
        obs_t o;
        int   ticks = 0;
        int   toggles = 0;
        logic prev;
        prev = clk_out;
        run  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (tick_out === 1'b1) ticks++;
            if (clk_out !== prev) toggles++;
            prev = clk_out;
        end
        n_checks++;
        if (ticks != 4) begin n_fail++; $display("FAIL tap0_ticks: got %0d need 4", ticks); end
        n_checks++;
        if (toggles != 8) begin n_fail++; $display("FAIL tap0_toggles: got %0d need 8", toggles); end
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL tap0_busy: got %b need 1", busy); end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL tap0_trace: got %h need %h", o, e); end
        end
    endtask

    task automatic test_switch();
        obs_t e;
        obs_t o;
        int   k = 0;
        int   len = 0;
        int   min_len = 1000;
        bit   seen = 1'b0;
        logic prev;
        sel_if.sel_valid = 1'b1; sel_if.sel_data = 5'd3;
        cycle();
        sel_if.sel_valid = 1'b0;
        while (sel_if.sel_ready !== 1'b1 && k < 40) begin cycle(); k++; end
        n_checks++;
        if (active_sel !== 5'd3) begin n_fail++; $display("FAIL switch_to3: got %0d need 3", active_sel); end
        repeat (20) cycle();
        prev = clk_out;
        for (int i = 0; i < 48; i++) begin
            if (i == 0) begin sel_if.sel_valid = 1'b1; sel_if.sel_data = 5'd1; end
            cycle();
            sel_if.sel_valid = 1'b0;
            if (i == 0) begin
                n_checks++;
                if (sel_if.sel_ready !== 1'b0) begin n_fail++; $display("FAIL switch_ready_drop: got %b need 0", sel_if.sel_ready); end
            end
            if (clk_out === prev) begin
                len++;
            end else begin
                if (seen && len < min_len) min_len = len;
                seen = 1'b1; len = 1; prev = clk_out;
            end
        end
        n_checks++;
        if (!seen || min_len < 2) begin n_fail++; $display("FAIL switch_runt: got min pulse %0d need >=2", min_len); end
        n_checks++;
        if (active_sel !== 5'd1 || sel_if.sel_ready !== 1'b1) begin
            n_fail++; $display("FAIL switch_to1: got sel=%0d rdy=%b need 1 1", active_sel, sel_if.sel_ready);
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL switch_trace: got %h need %h", o, e); end
        end
    endtask

    task automatic test_bad_sel();
        obs_t e;
        obs_t o;
        int   k = 0;
        int   p = 0;
        sel_if.sel_valid = 1'b1; sel_if.sel_data = 5'd25;
        cycle();
        sel_if.sel_valid = 1'b0;
        n_checks++;
        if (sel_if.sel_err !== 1'b1) begin n_fail++; $display("FAIL bad_sel_err_pulse: got %b need 1", sel_if.sel_err); end
        cycle();
        n_checks++;
        if (sel_if.sel_err !== 1'b0) begin n_fail++; $display("FAIL bad_sel_err_clear: got %b need 0", sel_if.sel_err); end
        n_checks++;
        if (active_sel !== 5'd1) begin n_fail++; $display("FAIL bad_sel_active: got %0d need 1", active_sel); end
        while (tick_out !== 1'b1 && k < 10) begin cycle(); k++; end
        do begin cycle(); p++; end while (tick_out !== 1'b1 && p < 10);
        n_checks++;
        if (p != 4) begin n_fail++; $display("FAIL bad_sel_period: got %0d need 4", p); end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL bad_sel_trace: got %h need %h", o, e); end
        end
    endtask

    task automatic test_stop_mid_high();
        obs_t e;
        obs_t o;
        int   k = 0;
        int   high_len = 0;
        sel_if.sel_valid = 1'b1; sel_if.sel_data = 5'd2;
        cycle();
        sel_if.sel_valid = 1'b0;
        while (sel_if.sel_ready !== 1'b1 && k < 20) begin cycle(); k++; end
        k = 0;
        while (tick_out !== 1'b1 && k < 16) begin cycle(); k++; end
        high_len = 1;
        cycle();
        if (clk_out === 1'b1) high_len++;
        run = 1'b0;
        k = 0;
        while (busy === 1'b1 && k < 16) begin
            cycle(); k++;
            if (clk_out === 1'b1) high_len++;
        end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL stop_busy: got %b need 0", busy); end
        n_checks++;
        if (clk_out !== 1'b0) begin n_fail++; $display("FAIL stop_clk_low: got %b need 0", clk_out); end
        n_checks++;
        if (high_len != 4) begin n_fail++; $display("FAIL stop_high_complete: got %0d need 4", high_len); end
        cycle();
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL stop_trace: got %h need %h", o, e); end
        end
    endtask

    task automatic test_stop_during_switch();
        obs_t e;
        obs_t o;
        int   k = 0;
        int   n = 0;
        sel_if.sel_valid = 1'b1; sel_if.sel_data = 5'd0;
        cycle();
        sel_if.sel_valid = 1'b0;
        n_checks++;
        if (active_sel !== 5'd0) begin n_fail++; $display("FAIL stop_sel_update: got %0d need 0", active_sel); end
        run = 1'b1;
        repeat (5) cycle();
        sel_if.sel_valid = 1'b1; sel_if.sel_data = 5'd4;
        cycle();
        sel_if.sel_valid = 1'b0;
        run = 1'b0;
        n_checks++;
        if (sel_if.sel_ready !== 1'b0) begin n_fail++; $display("FAIL sw_stop_ready: got %b need 0", sel_if.sel_ready); end
        while (busy === 1'b1 && k < 64) begin cycle(); k++; end
        n_checks++;
        if (active_sel !== 5'd4 || busy !== 1'b0 || clk_out !== 1'b0) begin
            n_fail++; $display("FAIL sw_stop_end: got sel=%0d busy=%b clk=%b need 4 0 0", active_sel, busy, clk_out);
        end
        run = 1'b1;
        do begin cycle(); n++; end while (clk_out !== 1'b1 && n < 40);
        n_checks++;
        if (n != 16 || tick_out !== 1'b1) begin
            n_fail++; $display("FAIL restart_latency: got %0d tick=%b need 16 1", n, tick_out);
        end
        run = 1'b0;
        k = 0;
        while (busy === 1'b1 && k < 40) begin cycle(); k++; end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL sw_stop_trace: got %h need %h", o, e); end
        end
    endtask

    task automatic test_reset_mid_switch();
        obs_t e;
        obs_t o;
        int   k = 0;
        sel_if.sel_valid = 1'b1; sel_if.sel_data = 5'd0; run = 1'b1;
        cycle();
        sel_if.sel_valid = 1'b0;
        repeat (3) cycle();
        sel_if.sel_valid = 1'b1; sel_if.sel_data = 5'd21;
        cycle();
        sel_if.sel_valid = 1'b0;
        repeat (5) cycle();
        n_checks++;
        if (sel_if.sel_ready !== 1'b0) begin n_fail++; $display("FAIL rst_pre_switch: got %b need 0", sel_if.sel_ready); end
        rst = 1'b1; run = 1'b0;
        cycle();
        n_checks++;
        if ({active_sel, clk_out, tick_out, busy, sel_if.sel_ready, sel_if.sel_err} !== 10'b00000_0_0_0_1_0) begin
            n_fail++;
            $display("FAIL rst_mid_switch: got sel=%0d clk=%b tick=%b busy=%b rdy=%b err=%b, need 0 0 0 0 1 0",
                     active_sel, clk_out, tick_out, busy, sel_if.sel_ready, sel_if.sel_err);
        end
        rst = 1'b0;
        run = 1'b1;
        repeat (6) cycle();
        n_checks++;
        if (active_sel !== 5'd0 || sel_if.sel_ready !== 1'b1) begin
            n_fail++; $display("FAIL rst_pend_dropped: got sel=%0d rdy=%b need 0 1", active_sel, sel_if.sel_ready);
        end
        run = 1'b0;
        while (busy === 1'b1 && k < 8) begin cycle(); k++; end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL rst_sw_trace: got %h need %h", o, e); end
        end
    endtask

    task automatic test_back_to_back();
        obs_t e;
        obs_t o;
        int   k = 0;
        sel_if.sel_valid = 1'b1; sel_if.sel_data = 5'd5;
        cycle();
        n_checks++;
        if (active_sel !== 5'd5) begin n_fail++; $display("FAIL b2b_first: got %0d need 5", active_sel); end
        sel_if.sel_data = 5'd7;
        cycle();
        n_checks++;
        if (active_sel !== 5'd7) begin n_fail++; $display("FAIL b2b_second: got %0d need 7", active_sel); end
        sel_if.sel_data = 5'd30;
        cycle();
        sel_if.sel_valid = 1'b0;
        n_checks++;
        if (sel_if.sel_err !== 1'b1 || active_sel !== 5'd7) begin
            n_fail++; $display("FAIL b2b_invalid: got err=%b sel=%0d need 1 7", sel_if.sel_err, active_sel);
        end
        run = 1'b1;
        sel_if.sel_valid = 1'b1; sel_if.sel_data = 5'd7;
        cycle();
        sel_if.sel_valid = 1'b0;
        cycle();
        n_checks++;
        if (sel_if.sel_ready !== 1'b1 || busy !== 1'b1 || active_sel !== 5'd7) begin
            n_fail++; $display("FAIL same_sel_no_switch: got rdy=%b busy=%b sel=%0d need 1 1 7",
                               sel_if.sel_ready, busy, active_sel);
        end
        repeat (10) cycle();
        run = 1'b0;
        while (busy === 1'b1 && k < 300) begin cycle(); k++; end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_stop: got busy=%b need 0", busy); end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL b2b_trace: got %h need %h", o, e); end
        end
    endtask

    initial begin
        test_reset();
        test_tap0();
        test_switch();
        test_bad_sel();
        test_stop_mid_high();
        test_stop_during_switch();
        test_reset_mid_switch();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
